// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state types and constants for the LCD timing output stage
package lcd_pkg;

  typedef enum logic [1:0] {H_SYNC, H_BP, H_ACTIVE, H_FP} h_state_t;
  typedef enum logic [1:0] {V_SYNC, V_BP, V_ACTIVE, V_FP} v_state_t;

  localparam int PIX_PER_GROUP = 16;
  localparam int GROUP_BITS    = $clog2(PIX_PER_GROUP);

endpackage

// File: rtl/lcd_pix_fifo.sv
// rtl/lcd_pix_fifo.sv - show-ahead synchronous pixel FIFO with flush
module lcd_pix_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 24
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DW-1:0]            dout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Guard against misuse even though the caller already gates on full/empty.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy tracking; flush behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_timing_out.sv
// rtl/lcd_timing_out.sv - pixel buffer, panel timing generator and registered LCD outputs
module lcd_timing_out
  import lcd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pixel_in,
  input  logic          pixel_valid,
  output logic          stall,
  input  logic          en,
  input  logic [5:0]    ppl,
  input  logic [7:0]    hsw,
  input  logic [7:0]    hbp,
  input  logic [7:0]    hfp,
  input  logic [9:0]    lpp,
  input  logic [5:0]    vsw,
  input  logic [7:0]    vbp,
  input  logic [7:0]    vfp,
  input  logic [4:0]    pcd,
  output logic [DW-1:0] lcd_vd,
  output logic          lcd_enab,
  output logic          lcd_lp,
  output logic          lcd_fp,
  output logic          lcd_dclk_en,
  output logic          underflow
);

  logic                  idle;
  logic                  tick, act_tick, line_end;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  fifo_count_unused;
  logic [DW-1:0]         fifo_dout;

  logic [4:0]  div_q, div_d;
  h_state_t    h_q, h_d;
  v_state_t    v_q, v_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0]  h_len_last, v_len_last, act_last;

  logic [DW-1:0] lcd_vd_q;
  logic          lcd_enab_q, lcd_lp_q, lcd_fp_q, lcd_dclk_en_q, underflow_q;

  assign idle      = reset | ~en;
  assign stall     = ~en | fifo_full;
  assign fifo_push = pixel_valid & ~stall;
  assign tick      = ~idle & (div_q == pcd);
  assign act_tick  = tick & (h_q == H_ACTIVE) & (v_q == V_ACTIVE);
  assign fifo_pop  = act_tick & ~fifo_empty;

  // Occupancy is exported by the FIFO for observation; the timing logic only needs full/empty.
  assign fifo_count_unused = ^fifo_count;

  // Last active pixel index of a line: groups of 16 pixels, minus one.
  assign act_last = {ppl + 6'd1, {GROUP_BITS{1'b0}}} - 10'd1;

  lcd_pix_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (~en),
    .push_i  (fifo_push),
    .din_i   (pixel_in),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .dout_o  (fifo_dout)
  );

  // Pixel clock divider: wraps at pcd, producing the tick.
  always_comb begin
    div_d = div_q;
    if (!idle) div_d = tick ? 5'd0 : div_q + 5'd1;
  end

  // Horizontal FSM next state; zero-length porches are skipped on entry.
  always_comb begin
    h_d        = h_q;
    h_cnt_d    = h_cnt_q;
    line_end   = 1'b0;
    h_len_last = '0;
    unique case (h_q)
      H_SYNC:   h_len_last = {2'b0, hsw};
      H_BP:     h_len_last = {2'b0, hbp} - 10'd1;
      H_ACTIVE: h_len_last = act_last;
      H_FP:     h_len_last = {2'b0, hfp} - 10'd1;
    endcase
    if (tick) begin
      if (h_cnt_q == h_len_last) begin
        h_cnt_d = '0;
        unique case (h_q)
          H_SYNC:   h_d = (hbp != 8'd0) ? H_BP : H_ACTIVE;
          H_BP:     h_d = H_ACTIVE;
          H_ACTIVE: begin
            h_d      = (hfp != 8'd0) ? H_FP : H_SYNC;
            line_end = (hfp == 8'd0);
          end
          H_FP: begin
            h_d      = H_SYNC;
            line_end = 1'b1;
          end
        endcase
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Vertical FSM next state, stepping once per completed line.
  always_comb begin
    v_d        = v_q;
    v_cnt_d    = v_cnt_q;
    v_len_last = '0;
    unique case (v_q)
      V_SYNC:   v_len_last = {4'b0, vsw};
      V_BP:     v_len_last = {2'b0, vbp} - 10'd1;
      V_ACTIVE: v_len_last = lpp;
      V_FP:     v_len_last = {2'b0, vfp} - 10'd1;
    endcase
    if (line_end) begin
      if (v_cnt_q == v_len_last) begin
        v_cnt_d = '0;
        unique case (v_q)
          V_SYNC:   v_d = (vbp != 8'd0) ? V_BP : V_ACTIVE;
          V_BP:     v_d = V_ACTIVE;
          V_ACTIVE: v_d = (vfp != 8'd0) ? V_FP : V_SYNC;
          V_FP:     v_d = V_SYNC;
        endcase
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  // Timing state registers; idle parks both FSMs at the start of a frame.
  always_ff @(posedge clk) begin
    if (idle) begin
      div_q   <= '0;
      h_q     <= H_SYNC;
      v_q     <= V_SYNC;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Panel outputs registered one clock after the tick; pixel data holds between ticks.
  always_ff @(posedge clk) begin
    if (idle) begin
      lcd_vd_q      <= '0;
      lcd_enab_q    <= 1'b0;
      lcd_lp_q      <= 1'b0;
      lcd_fp_q      <= 1'b0;
      lcd_dclk_en_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      lcd_enab_q    <= act_tick;
      lcd_dclk_en_q <= tick;
      lcd_lp_q      <= (h_q == H_SYNC);
      lcd_fp_q      <= (v_q == V_SYNC);
      if (act_tick) begin
        lcd_vd_q <= fifo_empty ? '0 : fifo_dout;
        if (fifo_empty) underflow_q <= 1'b1;
      end
    end
  end

  assign lcd_vd      = lcd_vd_q;
  assign lcd_enab    = lcd_enab_q;
  assign lcd_lp      = lcd_lp_q;
  assign lcd_fp      = lcd_fp_q;
  assign lcd_dclk_en = lcd_dclk_en_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_lcd_timing_out.sv
// tb/tb_lcd_timing_out.sv - scoreboard bench for lcd_timing_out against a frame-arithmetic model
module tb_lcd_timing_out;

  localparam int DEPTH = 16;
  localparam int DW    = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          stall;
  logic          en = 1'b0;
  logic [5:0]    ppl = '0;
  logic [7:0]    hsw = '0, hbp = '0, hfp = '0;
  logic [9:0]    lpp = '0;
  logic [5:0]    vsw = '0;
  logic [7:0]    vbp = '0, vfp = '0;
  logic [4:0]    pcd = '0;
  logic [DW-1:0] lcd_vd;
  logic          lcd_enab, lcd_lp, lcd_fp, lcd_dclk_en, underflow;

  always #5 clk = ~clk;

  lcd_timing_out #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .stall       (stall),
    .en          (en),
    .ppl         (ppl),
    .hsw         (hsw),
    .hbp         (hbp),
    .hfp         (hfp),
    .lpp         (lpp),
    .vsw         (vsw),
    .vbp         (vbp),
    .vfp         (vfp),
    .pcd         (pcd),
    .lcd_vd      (lcd_vd),
    .lcd_enab    (lcd_enab),
    .lcd_lp      (lcd_lp),
    .lcd_fp      (lcd_fp),
    .lcd_dclk_en (lcd_dclk_en),
    .underflow   (underflow)
  );

  typedef struct packed {
    logic          enab;
    logic          lp;
    logic          fp;
    logic          uf;
    logic [DW-1:0] vd;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_m[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic          mon_on = 1'b0;

  // Reference model state
  int unsigned   clk_idx = 0;
  logic          m_uf = 1'b0;
  logic [DW-1:0] m_vd = '0;
  logic          m_idle_last = 1'b1;
  logic          m_tick_last = 1'b0;
  logic          m_acc_last = 1'b0;
  logic [DW-1:0] prev_vd = '0;

  int unsigned   pd, k, line_len, frame_len, hpos, line_no;
  int unsigned   hs_len, ha_start, ha_len, vs_len, va_start, va_len;
  logic          m_act, m_accept;
  exp_t          m_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position of each pixel tick inside the frame follows from plain division.
  always @(posedge clk) begin
    if (reset || !en) begin
      fifo_m.delete();
      clk_idx     = 0;
      m_uf        = 1'b0;
      m_vd        = '0;
      m_idle_last = 1'b1;
      m_tick_last = 1'b0;
      m_acc_last  = 1'b0;
    end else begin
      m_accept    = pixel_valid && (fifo_m.size() < DEPTH);
      pd          = pcd + 1;
      m_tick_last = ((clk_idx % pd) == pd - 1);
      if (m_tick_last) begin
        k         = clk_idx / pd;
        hs_len    = hsw + 1;
        ha_start  = hs_len + hbp;
        ha_len    = 16 * (ppl + 1);
        line_len  = ha_start + ha_len + hfp;
        vs_len    = vsw + 1;
        va_start  = vs_len + vbp;
        va_len    = lpp + 1;
        frame_len = va_start + va_len + vfp;
        hpos      = k % line_len;
        line_no   = (k / line_len) % frame_len;
        m_act     = (hpos >= ha_start) && (hpos < ha_start + ha_len) &&
                    (line_no >= va_start) && (line_no < va_start + va_len);
        if (m_act) begin
          if (fifo_m.size() > 0) m_vd = fifo_m.pop_front();
          else begin
            m_vd = '0;
            m_uf = 1'b1;
          end
        end
        m_e.enab = m_act;
        m_e.lp   = (hpos < hs_len);
        m_e.fp   = (line_no < vs_len);
        m_e.uf   = m_uf;
        m_e.vd   = m_vd;
        exp_q.push_back(m_e);
      end
      if (m_accept) fifo_m.push_back(pixel_in);
      m_acc_last  = m_accept;
      clk_idx++;
      m_idle_last = 1'b0;
    end
  end

  // Monitor: compares whenever the DUT presents a pixel tick, plus idle and hold rules.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("stall", stall, (!en || fifo_m.size() == DEPTH));
      chk("dclk_en", lcd_dclk_en, m_tick_last);
      if (m_idle_last) begin
        chk("idle_outputs", {lcd_vd, lcd_enab, lcd_lp, lcd_fp, lcd_dclk_en, underflow}, '0);
        chk("idle_fifo_count", dut.u_fifo.count_o, 0);
      end else if (lcd_dclk_en) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          chk("enab", lcd_enab, m_e.enab);
          chk("lp", lcd_lp, m_e.lp);
          chk("fp", lcd_fp, m_e.fp);
          chk("underflow", underflow, m_e.uf);
          chk("vd", lcd_vd, m_e.vd);
        end
      end else begin
        chk("enab_off_tick", lcd_enab, 0);
        chk("vd_hold", lcd_vd, prev_vd);
      end
      prev_vd = lcd_vd;
    end
  end

  task automatic run_phase(input int cycles, input int push_pct, input int max_push);
    int offered = 0;
    @(posedge clk); #1;
    en = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (!pixel_valid || m_acc_last) begin
        pixel_valid = (offered < max_push) && ($urandom_range(99) < push_pct);
        if (pixel_valid) begin
          pixel_in = DW'($urandom);
          offered++;
        end
      end
    end
    en = 1'b0;
    pixel_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int c_pcd, input int c_ppl, input int c_hsw, input int c_hbp,
                         input int c_hfp, input int c_lpp, input int c_vsw, input int c_vbp,
                         input int c_vfp);
    pcd = 5'(c_pcd);  ppl = 6'(c_ppl);
    hsw = 8'(c_hsw);  hbp = 8'(c_hbp);  hfp = 8'(c_hfp);
    lpp = 10'(c_lpp); vsw = 6'(c_vsw);  vbp = 8'(c_vbp);  vfp = 8'(c_vfp);
  endtask

  initial begin
    @(posedge clk); #1;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Minimal timing, FIFO kept full by a continuous source
    set_cfg(0, 0, 0, 0, 0, 1, 0, 0, 0);
    run_phase(300, 100, 1000);

    // Divided pixel clock with porches
    set_cfg(3, 0, 1, 2, 1, 2, 0, 1, 1);
    run_phase(800, 30, 1000);

    // Long vsync: FIFO fills to 16 and stalls until the first active line drains it
    set_cfg(0, 0, 0, 0, 0, 0, 40, 0, 0);
    run_phase(1600, 100, 20);

    // No data at all: underflow on first active tick and stays set
    set_cfg(1, 0, 1, 1, 1, 1, 0, 0, 0);
    run_phase(300, 0, 0);

    // Enable dropped mid active line, then re-enabled with the same timing
    set_cfg(0, 3, 0, 0, 0, 3, 0, 0, 0);
    run_phase(100, 100, 1000);
    run_phase(400, 60, 1000);

    // Randomized timing sets, some with zero porches
    for (int p = 0; p < 4; p++) begin
      set_cfg($urandom_range(3), $urandom_range(1), $urandom_range(3),
              ($urandom_range(1) != 0) ? $urandom_range(3) : 0,
              ($urandom_range(1) != 0) ? $urandom_range(3) : 0,
              $urandom_range(3), $urandom_range(2),
              ($urandom_range(1) != 0) ? $urandom_range(2) : 0,
              ($urandom_range(1) != 0) ? $urandom_range(2) : 0);
      run_phase(600 + $urandom_range(400), 20 + $urandom_range(80), 1000);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
